// File: rtl/exibidor_sequencia.sv
// exibidor_sequencia: presents the stored memory-game sequence on the LEDs.
// Addresses 0..limite are read from a synchronous ROM. Each entry is lit for
// T_ACESO cycles and then followed by a dark gap of T_APAGADO cycles. A single
// pronto pulse marks the end of the round.
// Optional build macro EXIBIDOR_VALIDA_ONEHOT_EN: an entry that is not one-hot
// is shown as 4'b1111 and sets the sticky erro_dado flag.
module exibidor_sequencia #(
    parameter int T_ACESO   = 1000,
    parameter int T_APAGADO = 500,
    parameter int CNT_W     = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] limite,
    input  logic [3:0] dado_mem,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       ativo,
    output logic       pronto,
    output logic       erro_dado,
    output logic [3:0] db_estado
);

    localparam logic [3:0] S_INICIAL = 4'h0;
    localparam logic [3:0] S_BUSCA   = 4'h1;
    localparam logic [3:0] S_CARREGA = 4'h2;
    localparam logic [3:0] S_ACESO   = 4'h3;
    localparam logic [3:0] S_APAGADO = 4'h4;
    localparam logic [3:0] S_PROXIMO = 4'h5;
    localparam logic [3:0] S_FIM     = 4'hF;

    localparam logic [CNT_W-1:0] ULT_ACESO   = CNT_W'(T_ACESO - 1);
    localparam logic [CNT_W-1:0] ULT_APAGADO = CNT_W'(T_APAGADO - 1);

    logic [3:0]       estado;
    logic [3:0]       prox_estado;
    logic [CNT_W-1:0] timer;
    logic [3:0]       limite_reg;

`ifdef EXIBIDOR_VALIDA_ONEHOT_EN
    logic erro_reg;

    function automatic logic eh_one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset)
            estado <= S_INICIAL;
        else
            estado <= prox_estado;
    end

    // Next-state logic: the timer decides how long ACESO and APAGADO last
    always_comb begin
        prox_estado = estado;
        case (estado)
            S_INICIAL: if (iniciar) prox_estado = S_BUSCA;
            S_BUSCA:   prox_estado = S_CARREGA;
            S_CARREGA: prox_estado = S_ACESO;
            S_ACESO:   if (timer == ULT_ACESO) prox_estado = S_APAGADO;
            S_APAGADO: if (timer == ULT_APAGADO) prox_estado = S_PROXIMO;
            S_PROXIMO: prox_estado = (endereco == limite_reg) ? S_FIM : S_BUSCA;
            S_FIM:     prox_estado = S_INICIAL;
            default:   prox_estado = S_INICIAL;
        endcase
    end

    // Address, LED, timer and limit registers, all updated per state
    always_ff @(posedge clock) begin
        if (reset) begin
            endereco   <= 4'd0;
            leds       <= 4'd0;
            timer      <= '0;
            limite_reg <= 4'd0;
        end else begin
            case (estado)
                S_INICIAL: begin
                    if (iniciar) begin
                        limite_reg <= limite;
                        endereco   <= 4'd0;
                        timer      <= '0;
                        leds       <= 4'd0;
                    end
                end
                S_CARREGA: begin
                    timer <= '0;
`ifdef EXIBIDOR_VALIDA_ONEHOT_EN
                    leds  <= eh_one_hot(dado_mem) ? dado_mem : 4'b1111;
`else
                    leds  <= dado_mem;
`endif
                end
                S_ACESO: begin
                    if (timer == ULT_ACESO) begin
                        leds  <= 4'd0;
                        timer <= '0;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                S_APAGADO: begin
                    if (timer == ULT_APAGADO)
                        timer <= '0;
                    else
                        timer <= timer + CNT_W'(1);
                end
                S_PROXIMO: begin
                    // The last address is held, so limite=15 never wraps to 0
                    if (endereco != limite_reg)
                        endereco <= endereco + 4'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef EXIBIDOR_VALIDA_ONEHOT_EN
    // Sticky bad-entry flag: set at the end of CARREGA, cleared by reset or a new round
    always_ff @(posedge clock) begin
        if (reset)
            erro_reg <= 1'b0;
        else if (estado == S_INICIAL && iniciar)
            erro_reg <= 1'b0;
        else if (estado == S_CARREGA && !eh_one_hot(dado_mem))
            erro_reg <= 1'b1;
    end

    assign erro_dado = erro_reg;
`else
    assign erro_dado = 1'b0;
`endif

    // Status outputs are decoded from the state register only
    always_comb begin
        ativo     = (estado != S_INICIAL) && (estado != S_FIM);
        pronto    = (estado == S_FIM);
        db_estado = estado;
    end

endmodule

// File: tb/tb_exibidor_sequencia.sv
// Bench for exibidor_sequencia with short timing (T_ACESO=4, T_APAGADO=2).
// A round-level model predicts every output from the start cycle, the latched
// limit and the ROM contents. Directed scenarios add literal expectations.
module tb_exibidor_sequencia;

    localparam int TA = 4;
    localparam int TP = 2;
    localparam int P  = 3 + TA + TP;
`ifdef EXIBIDOR_VALIDA_ONEHOT_EN
    localparam bit CHECK_ON = 1'b1;
`else
    localparam bit CHECK_ON = 1'b0;
`endif

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       iniciar = 1'b0;
    logic [3:0] limite  = 4'd0;
    logic [3:0] dado_mem = 4'd0;
    logic [3:0] endereco, leds, db_estado;
    logic       ativo, pronto, erro_dado;

    logic [3:0] rom [16];
    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;

    exibidor_sequencia #(.T_ACESO(TA), .T_APAGADO(TP), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .limite(limite),
        .dado_mem(dado_mem), .endereco(endereco), .leds(leds), .ativo(ativo),
        .pronto(pronto), .erro_dado(erro_dado), .db_estado(db_estado)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) dado_mem <= rom[endereco];

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s at cycle %0d: got %0h expected %0h", nome, cyc, act, exp);
        end
    endtask

    function automatic logic bad4(input logic [3:0] v);
        int cnt = 0;
        for (int b = 0; b < 4; b++) if (v[b]) cnt++;
        return CHECK_ON && (cnt != 1);
    endfunction

    function automatic logic [3:0] show4(input logic [3:0] v);
        return bad4(v) ? 4'hF : v;
    endfunction

    function automatic logic any_bad(input int upto);
        for (int j = 0; j <= upto; j++) if (bad4(rom[j])) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int fim_n(input int l);
        return 1 + (l + 1) * P;
    endfunction

    // Model state: one round at a time, idle values remembered between rounds
    bit         m_valid = 0;
    bit         m_run   = 0;
    int         m_start = 0;
    int         m_lim   = 0;
    logic [3:0] m_idle_addr = 4'd0;
    logic       m_idle_erro = 1'b0;
    int         n, ie, off;
    logic [3:0] e_leds, e_addr, e_est;
    logic       e_ativo, e_pronto, e_erro;

    always @(posedge clock) begin
        #1;
        if (reset) begin
            m_valid = 1; m_run = 0; m_idle_addr = 4'd0; m_idle_erro = 1'b0;
        end else if (m_valid && iniciar && !m_run) begin
            m_run = 1; m_start = cyc - 1; m_lim = int'(limite);
        end
        if (m_run && (cyc - m_start) > fim_n(m_lim)) begin
            m_idle_addr = m_lim[3:0]; m_idle_erro = any_bad(m_lim); m_run = 0;
        end
        if (m_valid) begin
            e_leds = 4'd0; e_addr = m_idle_addr; e_ativo = 1'b0; e_pronto = 1'b0;
            e_erro = m_idle_erro; e_est = 4'h0;
            if (m_run) begin
                n = cyc - m_start;
                if (n == fim_n(m_lim)) begin
                    e_pronto = 1'b1; e_addr = m_lim[3:0]; e_erro = any_bad(m_lim); e_est = 4'hF;
                end else if (n >= 1) begin
                    ie = (n - 1) / P; off = (n - 1) % P;
                    e_ativo = 1'b1; e_addr = ie[3:0];
                    e_erro = (ie > 0 && any_bad(ie - 1)) || (bad4(rom[ie]) && off >= 2);
                    if (off == 0) e_est = 4'h1;
                    else if (off == 1) e_est = 4'h2;
                    else if (off < 2 + TA) begin e_est = 4'h3; e_leds = show4(rom[ie]); end
                    else if (off < 2 + TA + TP) e_est = 4'h4;
                    else e_est = 4'h5;
                end
            end
            chk("model_leds", leds, e_leds);
            chk("model_endereco", endereco, e_addr);
            chk("model_ativo", ativo, e_ativo);
            chk("model_pronto", pronto, e_pronto);
            chk("model_erro_dado", erro_dado, e_erro);
            chk("model_db_estado", db_estado, e_est);
        end
    end

    task automatic go(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    task automatic iniciar_rodada(input logic [3:0] lim, output int s);
        s = cyc; iniciar = 1'b1; limite = lim;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    initial begin
        int s;
        bit seen;
        for (int i = 0; i < 16; i++) rom[i] = 4'd0;
        repeat (3) @(negedge clock);
        chk("reset_leds", leds, 0);
        chk("reset_endereco", endereco, 0);
        chk("reset_ativo", ativo, 0);
        chk("reset_pronto", pronto, 0);
        chk("reset_erro", erro_dado, 0);
        chk("reset_estado", db_estado, 0);
        reset = 1'b0;
        @(negedge clock);

        // Single entry
        rom[0] = 4'b0001;
        iniciar_rodada(4'd0, s);
        go(s + 2);  chk("s1_leds_c2", leds, 0);
        go(s + 3);  chk("s1_leds_c3", leds, 4'b0001);
        go(s + 6);  chk("s1_leds_c6", leds, 4'b0001);
        go(s + 7);  chk("s1_leds_c7", leds, 0);
        go(s + 9);  chk("s1_ativo_c9", ativo, 1); chk("s1_pronto_c9", pronto, 0);
        go(s + 10); chk("s1_pronto_c10", pronto, 1); chk("s1_ativo_c10", ativo, 0);
        chk("s1_end_c10", endereco, 0);
        go(s + 12);

        // Four entries, with an ignored start pulse during APAGADO
        rom[0] = 4'b0001; rom[1] = 4'b0010; rom[2] = 4'b0100; rom[3] = 4'b1000;
        iniciar_rodada(4'd3, s);
        go(s + 7);  chk("s2_estado_apagado", db_estado, 4'h4);
        iniciar = 1'b1; @(negedge clock); iniciar = 1'b0;
        go(s + 12); chk("s2_leds_c12", leds, 4'b0010);
        go(s + 21); chk("s2_leds_c21", leds, 4'b0100);
        go(s + 30); chk("s2_leds_c30", leds, 4'b1000);
        go(s + 36); chk("s2_end_c36", endereco, 3); chk("s2_pronto_c36", pronto, 0);
        go(s + 37); chk("s2_pronto_c37", pronto, 1);
        go(s + 39);

        // Maximum length: 16 entries, no address wrap
        for (int i = 0; i < 16; i++) rom[i] = 4'(1 << (i % 4));
        iniciar_rodada(4'd15, s);
        go(s + 144); chk("s3_end_c144", endereco, 15);
        go(s + 145); chk("s3_pronto_c145", pronto, 1); chk("s3_end_c145", endereco, 15);
        go(s + 146); chk("s3_end_c146", endereco, 15); chk("s3_ativo_c146", ativo, 0);
        go(s + 148);

        // Limit is latched at start; later changes do not matter
        iniciar_rodada(4'd1, s);
        limite = 4'd5;
        go(s + 18); chk("s5_ativo_c18", ativo, 1);
        go(s + 19); chk("s5_pronto_c19", pronto, 1);
        go(s + 20); chk("s5_ativo_c20", ativo, 0);
        go(s + 22);

        // Reset during ACESO of entry 2 aborts the round without pronto
        iniciar_rodada(4'd3, s);
        go(s + 22); chk("s4_leds_entry2", leds, 4'b0100);
        reset = 1'b1; @(negedge clock); reset = 1'b0;
        chk("s4_rst_leds", leds, 0);
        chk("s4_rst_end", endereco, 0);
        chk("s4_rst_estado", db_estado, 0);
        seen = 0;
        while (cyc < s + 45) begin
            if (pronto) seen = 1;
            @(negedge clock);
        end
        chk("s4_no_pronto", seen, 0);

        // Non-one-hot entry
        rom[0] = 4'b0001; rom[1] = 4'b0011;
        iniciar_rodada(4'd1, s);
        go(s + 11); chk("s6_erro_c11", erro_dado, 0);
        go(s + 12); chk("s6_leds_c12", leds, CHECK_ON ? 4'b1111 : 4'b0011);
        chk("s6_erro_c12", erro_dado, CHECK_ON);
        go(s + 19); chk("s6_pronto_c19", pronto, 1);
        go(s + 20); chk("s6_erro_after", erro_dado, CHECK_ON);
        go(s + 22);
        rom[1] = 4'b0010;
        chk("s6_erro_idle", erro_dado, CHECK_ON);
        iniciar_rodada(4'd1, s);
        chk("s6_erro_cleared", erro_dado, 0);
        go(s + 22);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
